// File: rtl/mem_arbiter_pkg.sv
// Shared types for the instruction/data memory arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } state_t;

    typedef enum logic {
        OWN_I,
        OWN_D
    } owner_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Fetch, load/store and memory-side signals of the arbiter.
interface mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic [DATA_W-1:0] i_rdata;
    logic              i_valid;
    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic [DATA_W-1:0] d_rdata;
    logic              d_valid;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              busy;

    modport slave (
        input  i_req, i_addr,
        input  d_req, d_we, d_addr, d_wdata,
        input  mem_rdata,
        output i_rdata, i_valid,
        output d_rdata, d_valid,
        output mem_en, mem_we, mem_addr, mem_wdata,
        output busy
    );

    modport master (
        output i_req, i_addr,
        output d_req, d_we, d_addr, d_wdata,
        output mem_rdata,
        input  i_rdata, i_valid,
        input  d_rdata, d_valid,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        input  busy
    );
endinterface

// File: rtl/mem_arbiter_lat_counter.sv
// Loadable saturating down-counter timing the memory read latency.
module lat_counter #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         dec_i,
    output logic [W-1:0] cnt_o,
    output logic         zero_o
);
    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && cnt_q != '0) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o  = cnt_q;
    assign zero_o = (cnt_q == '0);
endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates one fixed-latency memory between fetch and load/store,
// data first, with a streak limit that bounds fetch starvation.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int LATENCY  = 2,
    parameter int D_STREAK = 4
) (
    input logic          clk,
    input logic          reset_n,
    mem_arbiter_if.slave bus
);
    localparam int CW = $clog2(LATENCY + 1);
    localparam int SW = $clog2(D_STREAK + 1);
    localparam logic [CW-1:0] LOAD_VAL = CW'(LATENCY - 1);
    localparam logic [SW-1:0] S_MAX    = SW'(D_STREAK);

    state_t            state_q;
    owner_t            own_q;
    logic [SW-1:0]     streak_q;
    logic              mem_en_q;
    logic              mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;
    logic [DATA_W-1:0] i_rdata_q;
    logic [DATA_W-1:0] d_rdata_q;
    logic              i_valid_q;
    logic              d_valid_q;

    logic          gnt_d_d;
    logic          gnt_i_d;
    logic [CW-1:0] cnt;
    logic          cnt_zero;
    logic          wait_done;

    assign gnt_d_d = bus.d_req &&
                     !(bus.i_req && streak_q == S_MAX);
    assign gnt_i_d = bus.i_req && !gnt_d_d;

    lat_counter #(.W(CW)) u_lat (
        .clk       (clk),
        .reset_n   (reset_n),
        .load_i    (state_q == ISSUE),
        .load_val_i(LOAD_VAL),
        .dec_i     (state_q == WAIT),
        .cnt_o     (cnt),
        .zero_o    (cnt_zero)
    );

    // Done on the cycle the decrement reaches zero, so WAIT spans
    // LATENCY-1 cycles, and a single cycle when LATENCY is 1.
    assign wait_done = cnt_zero || (cnt == CW'(1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            own_q       <= OWN_I;
            streak_q    <= '0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            i_rdata_q   <= '0;
            d_rdata_q   <= '0;
            i_valid_q   <= 1'b0;
            d_valid_q   <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (!bus.i_req || gnt_i_d) begin
                        streak_q <= '0;
                    end else if (gnt_d_d && streak_q != S_MAX) begin
                        streak_q <= streak_q + SW'(1);
                    end
                    if (gnt_d_d) begin
                        own_q       <= OWN_D;
                        mem_addr_q  <= bus.d_addr;
                        mem_we_q    <= bus.d_we;
                        mem_wdata_q <= bus.d_wdata;
                        mem_en_q    <= 1'b1;
                        state_q     <= ISSUE;
                    end else if (gnt_i_d) begin
                        own_q       <= OWN_I;
                        mem_addr_q  <= bus.i_addr;
                        mem_we_q    <= 1'b0;
                        mem_wdata_q <= '0;
                        mem_en_q    <= 1'b1;
                        state_q     <= ISSUE;
                    end
                end
                ISSUE: begin
                    mem_en_q <= 1'b0;
                    state_q  <= WAIT;
                end
                WAIT: begin
                    if (wait_done) begin
                        if (own_q == OWN_I) begin
                            i_rdata_q <= bus.mem_rdata;
                            i_valid_q <= 1'b1;
                        end else begin
                            if (!mem_we_q) begin
                                d_rdata_q <= bus.mem_rdata;
                            end
                            d_valid_q <= 1'b1;
                        end
                        state_q <= RESP;
                    end
                end
                RESP: begin
                    i_valid_q <= 1'b0;
                    d_valid_q <= 1'b0;
                    state_q   <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.mem_en    = mem_en_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.i_rdata   = i_rdata_q;
    assign bus.i_valid   = i_valid_q;
    assign bus.d_rdata   = d_rdata_q;
    assign bus.d_valid   = d_valid_q;
    assign bus.busy      = (state_q != IDLE);
endmodule
